md_sched: RTL and testbench

Multiply/divide scheduler for the pipelined MIPS core. Sits in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E-stage instruction, runs multi-cycle operations with a fixed-latency countdown, and owns the HI/LO registers. It also raises the D-stage stall request that holds later HI/LO-class instructions until the unit is free.

---
 rtl/md_sched_if.sv | 23 ++
 rtl/md_sched.sv | 138 +++++++++++++
 tb/tb_md_sched.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// rtl/md_sched_if.sv - E-stage HI/LO request and result bundle for md_sched
interface md_sched_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output start, md_op, rs_val, rt_val, d_is_md,
        input  busy, md_stall, hi, lo, md_out
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, d_is_md,
        output busy, md_stall, hi, lo, md_out
    );
endinterface

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide scheduler owning HI/LO with fixed-latency countdown
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [31:0]    hi_q, hi_next, lo_q, lo_next;
    logic [31:0]    p_hi, p_hi_next, p_lo, p_lo_next;
    logic           dz, dz_next;

    logic           is_long;
    logic [31:0]    div_rt;
    logic [63:0]    prod_s, prod_u;
    logic [31:0]    quot_s, rem_s, quot_u, rem_u;

    assign is_long = bus.start && (bus.md_op >= OP_MULT) && (bus.md_op <= OP_DIVU);

    // Divisor forced to 1 on zero so the divider never sees x/0; dz suppresses the commit.
    assign div_rt = (bus.rt_val == 32'd0) ? 32'd1 : bus.rt_val;
    assign prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) * $signed({{32{bus.rt_val[31]}}, bus.rt_val});
    assign prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
    assign quot_s = $signed(bus.rs_val) / $signed(div_rt);
    assign rem_s  = $signed(bus.rs_val) % $signed(div_rt);
    assign quot_u = bus.rs_val / div_rt;
    assign rem_u  = bus.rs_val % div_rt;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hi_next    = hi_q;
        lo_next    = lo_q;
        p_hi_next  = p_hi;
        p_lo_next  = p_lo;
        dz_next    = dz;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    case (bus.md_op)
                        OP_MULT: begin
                            p_hi_next  = prod_s[63:32];
                            p_lo_next  = prod_s[31:0];
                            dz_next    = 1'b0;
                            cnt_next   = CW'(MULT_CYCLES);
                            state_next = RUN;
                        end
                        OP_MULTU: begin
                            p_hi_next  = prod_u[63:32];
                            p_lo_next  = prod_u[31:0];
                            dz_next    = 1'b0;
                            cnt_next   = CW'(MULT_CYCLES);
                            state_next = RUN;
                        end
                        OP_DIV: begin
                            p_hi_next  = rem_s;
                            p_lo_next  = quot_s;
                            dz_next    = (bus.rt_val == 32'd0);
                            cnt_next   = CW'(DIV_CYCLES);
                            state_next = RUN;
                        end
                        OP_DIVU: begin
                            p_hi_next  = rem_u;
                            p_lo_next  = quot_u;
                            dz_next    = (bus.rt_val == 32'd0);
                            cnt_next   = CW'(DIV_CYCLES);
                            state_next = RUN;
                        end
                        OP_MTHI: hi_next = bus.rs_val;
                        OP_MTLO: lo_next = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    if (!dz) begin
                        hi_next = p_hi;
                        lo_next = p_lo;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            dz    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            hi_q  <= hi_next;
            lo_q  <= lo_next;
            p_hi  <= p_hi_next;
            p_lo  <= p_lo_next;
            dz    <= dz_next;
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.md_stall = bus.d_is_md && ((state == RUN) || is_long);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    always_comb begin
        case (bus.md_op)
            OP_MFHI: bus.md_out = hi_q;
            OP_MFLO: bus.md_out = lo_q;
            default: bus.md_out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - self-checking bench for md_sched
module tb_md_sched;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    md_sched_if bus ();

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        bus.start  = 1'b1;
        bus.md_op  = op;
        bus.rs_val = rs;
        bus.rt_val = rt;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.md_op  = 4'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    // Reference: architectural result from plain 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         inout logic [31:0] mhi, inout logic [31:0] mlo, output int cyc);
        longint a, b, p, q, r;
        longint unsigned ua, ub, up;
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        ua = {32'd0, rs};
        ub = {32'd0, rt};
        cyc = 0;
        case (op)
            4'd1: begin p = a * b; mhi = p[63:32]; mlo = p[31:0]; cyc = MC; end
            4'd2: begin up = ua * ub; mhi = up[63:32]; mlo = up[31:0]; cyc = MC; end
            4'd3: begin
                cyc = DC;
                if (rt != 0) begin q = a / b; r = a % b; mhi = r[31:0]; mlo = q[31:0]; end
            end
            4'd4: begin
                cyc = DC;
                if (rt != 0) begin up = ua / ub; mlo = up[31:0]; up = ua % ub; mhi = up[31:0]; end
            end
            4'd7: mhi = rs;
            4'd8: mlo = rs;
            default: ;
        endcase
    endtask

    initial begin
        int n, s;
        logic [31:0] mhi, mlo;
        logic [3:0]  op;
        logic [31:0] rs, rt;
        logic [3:0]  ops [6];

        tbl[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        tbl[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
        tbl[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        tbl[3] = '{4'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        tbl[4] = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, DC};
        tbl[5] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};
        tbl[6] = '{4'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MC};
        tbl[7] = '{4'd3, 32'h80000000, 32'd1,        32'h00000000, 32'h80000000, DC};

        bus.start = 1'b0; bus.md_op = 4'd0; bus.rs_val = '0; bus.rt_val = '0; bus.d_is_md = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_stall", {31'd0, bus.md_stall}, 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);

        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].op, tbl[i].rs, tbl[i].rt);
            wait_idle(n);
            chk($sformatf("tbl%0d_cycles", i), n, tbl[i].cycles);
            chk($sformatf("tbl%0d_hi", i), bus.hi, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), bus.lo, tbl[i].lo);
        end

        // Stall held over issue cycle and every busy cycle, then released.
        bus.d_is_md = 1'b1;
        bus.start = 1'b1; bus.md_op = 4'd1; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
        #1;
        s = bus.md_stall ? 1 : 0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.md_op = 4'd0;
        n = 0;
        while (bus.busy && n < 200) begin
            if (bus.md_stall) s++;
            n++;
            @(posedge clk); #1;
        end
        chk("stall_cycles", s, MC + 1);
        chk("stall_after", {31'd0, bus.md_stall}, 32'd0);

        bus.d_is_md = 1'b0;
        bus.start = 1'b1; bus.md_op = 4'd1;
        #1;
        s = bus.md_stall ? 1 : 0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.md_op = 4'd0;
        n = 0;
        while (bus.busy && n < 200) begin
            if (bus.md_stall) s++;
            n++;
            @(posedge clk); #1;
        end
        chk("nostall_cycles", s, 0);

        // mthi then mfhi directly after.
        issue(4'd7, 32'h12345678, 32'd0);
        bus.md_op = 4'd5; #1;
        chk("mfhi_after_mthi", bus.md_out, 32'h12345678);
        bus.md_op = 4'd0;

        // Starts during RUN are dropped.
        issue(4'd1, 32'd2, 32'd3);
        issue(4'd7, 32'hDEADBEEF, 32'd0);
        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n);
        chk("ignore_run_hi", bus.hi, 32'd0);
        chk("ignore_run_lo", bus.lo, 32'd6);

        // Reset in the third busy cycle of a divide.
        issue(4'd4, 32'd100, 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; #1;
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_hi", bus.hi, 32'd0);
        chk("rst_mid_lo", bus.lo, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (DC + 3) @(posedge clk);
        #1;
        chk("rst_late_hi", bus.hi, 32'd0);
        chk("rst_late_lo", bus.lo, 32'd0);
        chk("rst_late_busy", {31'd0, bus.busy}, 32'd0);

        // Randomised ops against the reference model.
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
        mhi = 32'd0; mlo = 32'd0;
        for (int k = 0; k < 40; k++) begin
            int exp_cyc;
            op = ops[$urandom_range(0, 5)];
            rs = $urandom;
            rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rt = rt & 32'h000000FF;
            if (op == 4'd3 && rs == 32'h80000000 && rt == 32'hFFFFFFFF) rt = 32'd1;
            model(op, rs, rt, mhi, mlo, exp_cyc);
            issue(op, rs, rt);
            wait_idle(n);
            chk($sformatf("rnd%0d_cycles", k), n, exp_cyc);
            chk($sformatf("rnd%0d_hi", k), bus.hi, mhi);
            chk($sformatf("rnd%0d_lo", k), bus.lo, mlo);
            bus.md_op = 4'd6; #1;
            chk($sformatf("rnd%0d_mflo", k), bus.md_out, mlo);
            bus.md_op = 4'd0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
